riscv_datapath: RTL and testbench

- Datapath of the RV32I single-cycle core. Holds the PC register, the 32x32 register file, the immediate extender, the ALU and the result/PC-next muxes.
- Driven by the control unit: PCSrc, ResultSrc, ALUSrc, ImmSrc, RegWrite, ALUControl.
- Talks to external data memory through ALUResult (address), WriteData, ReadData and DataSrc (width code).

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/riscv_regfile.sv | 36 +++
 rtl/riscv_datapath.sv | 116 +++++++++++
 tb/tb_riscv_datapath.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings and defaults for the RV32I single-cycle datapath.
package riscv_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } res_src_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

endpackage

// File: rtl/riscv_regfile.sv
// 32 x XLEN register file: two combinational read ports, one synchronous
// write port, synchronous clear. x0 is hardwired to zero on read.
module riscv_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic [4:0]      wa,
  input  logic            we,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [32];

  // Clear everything on reset; otherwise write wd to a non-zero register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  // Reads see the stored contents only; a same-cycle write is not forwarded.
  always_comb begin
    rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
  end

endmodule

// File: rtl/riscv_datapath.sv
// RV32I single-cycle datapath: PC, register file, immediate extender, ALU
// and the writeback / next-PC muxes. All outputs except PC are combinational.
module riscv_datapath #(
  parameter int          XLEN     = riscv_pkg::XLEN,
  parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic [31:0]     Instr,
  input  logic            PCSrc,
  input  logic [1:0]      ResultSrc,
  input  logic            ALUSrc,
  input  logic [1:0]      ImmSrc,
  input  logic            RegWrite,
  input  logic [2:0]      ALUControl,
  input  logic [XLEN-1:0] ReadData,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] WriteData,
  output logic            zero_flag,
  output logic [XLEN-1:0] ALUResult,
  output logic [XLEN-1:0] Final_Result,
  output logic [2:0]      DataSrc
);

  import riscv_pkg::*;

  logic [XLEN-1:0]        imm_ext;
  logic [XLEN-1:0]        rd1;
  logic [XLEN-1:0]        rd2;
  logic [XLEN-1:0]        src_b;
  logic signed [XLEN-1:0] src_a_s;
  logic signed [XLEN-1:0] src_b_s;
  logic [XLEN-1:0]        pc_plus4;
  logic [XLEN-1:0]        pc_target;
  logic [XLEN-1:0]        pc_next;
  logic [6:0]             unused_opcode;

  // The opcode field is decoded by the control unit, not here.
  assign unused_opcode = Instr[6:0];

  riscv_regfile #(.XLEN(XLEN)) u_regfile (
    .clk (clk),
    .rst (Reset),
    .ra1 (Instr[19:15]),
    .ra2 (Instr[24:20]),
    .wa  (Instr[11:7]),
    .we  (RegWrite),
    .wd  (Final_Result),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  // Immediate extender: every format sign-extends from Instr[31].
  always_comb begin
    imm_ext = '0;
    case (ImmSrc)
      IMM_I:   imm_ext = {{(XLEN-12){Instr[31]}}, Instr[31:20]};
      IMM_S:   imm_ext = {{(XLEN-12){Instr[31]}}, Instr[31:25], Instr[11:7]};
      IMM_B:   imm_ext = {{(XLEN-12){Instr[31]}}, Instr[7], Instr[30:25],
                          Instr[11:8], 1'b0};
      IMM_J:   imm_ext = {{(XLEN-20){Instr[31]}}, Instr[19:12], Instr[20],
                          Instr[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  assign src_b   = ALUSrc ? imm_ext : rd2;
  assign src_a_s = rd1;
  assign src_b_s = src_b;

  // ALU: wrapping arithmetic, signed set-less-than, 5-bit shift amounts.
  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      ALU_ADD: ALUResult = rd1 + src_b;
      ALU_SUB: ALUResult = rd1 - src_b;
      ALU_AND: ALUResult = rd1 & src_b;
      ALU_OR:  ALUResult = rd1 | src_b;
      ALU_XOR: ALUResult = rd1 ^ src_b;
      ALU_SLT: ALUResult = {{(XLEN-1){1'b0}}, (src_a_s < src_b_s)};
      ALU_SLL: ALUResult = rd1 << src_b[4:0];
      ALU_SRL: ALUResult = rd1 >> src_b[4:0];
      default: ALUResult = '0;
    endcase
  end

  assign zero_flag = (ALUResult == '0);
  assign pc_plus4  = PC + XLEN'(4);
  assign pc_target = PC + imm_ext;
  assign pc_next   = PCSrc ? pc_target : pc_plus4;

  // Writeback select.
  always_comb begin
    Final_Result = '0;
    case (ResultSrc)
      RES_ALU: Final_Result = ALUResult;
      RES_MEM: Final_Result = ReadData;
      RES_PC4: Final_Result = pc_plus4;
      RES_IMM: Final_Result = imm_ext;
      default: Final_Result = '0;
    endcase
  end

  // Program counter: load the reset vector or advance every cycle.
  always_ff @(posedge clk) begin
    if (Reset) begin
      PC <= XLEN'(RESET_PC);
    end else begin
      PC <= pc_next;
    end
  end

  assign WriteData = rd2;
  assign DataSrc   = Instr[14:12];

endmodule

// File: tb/tb_riscv_datapath.sv
// Directed bench for riscv_datapath: reset, store, addi, ALU ops,
// immediates, branches, jal and mid-run reset.
module tb_riscv_datapath;

  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        Reset;
  logic [31:0] Instr;
  logic        PCSrc;
  logic [1:0]  ResultSrc;
  logic        ALUSrc;
  logic [1:0]  ImmSrc;
  logic        RegWrite;
  logic [2:0]  ALUControl;
  logic [31:0] ReadData;
  logic [31:0] PC;
  logic [31:0] WriteData;
  logic        zero_flag;
  logic [31:0] ALUResult;
  logic [31:0] Final_Result;
  logic [2:0]  DataSrc;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;

  always #50 clk = ~clk;

  riscv_datapath dut (
    .clk          (clk),
    .Reset        (Reset),
    .Instr        (Instr),
    .PCSrc        (PCSrc),
    .ResultSrc    (ResultSrc),
    .ALUSrc       (ALUSrc),
    .ImmSrc       (ImmSrc),
    .RegWrite     (RegWrite),
    .ALUControl   (ALUControl),
    .ReadData     (ReadData),
    .PC           (PC),
    .WriteData    (WriteData),
    .zero_flag    (zero_flag),
    .ALUResult    (ALUResult),
    .Final_Result (Final_Result),
    .DataSrc      (DataSrc)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] exp;
  } alu_vec_t;

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'h33};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic pcsrc, input logic [1:0] rsrc,
                       input logic asrc, input logic [1:0] isrc, input logic rw,
                       input logic [2:0] op);
    Instr      = ins;
    PCSrc      = pcsrc;
    ResultSrc  = rsrc;
    ALUSrc     = asrc;
    ImmSrc     = isrc;
    RegWrite   = rw;
    ALUControl = op;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reads register r through the ALU as rs1 + 0 without writing anything.
  task automatic peek(input logic [4:0] r, output logic [31:0] v);
    drive(i_type(12'd0, r, 5'd0), 1'b0, RES_ALU, 1'b1, IMM_I, 1'b0, ALU_ADD);
    #1;
    v = ALUResult;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    Reset    = 1'b1;
    ReadData = 32'h0;
    drive(i_type(12'd10, 5'd0, 5'd5), 1'b0, RES_ALU, 1'b1, IMM_I, 1'b1, ALU_ADD);
    tick();
    n_checks++;
    if (PC !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pc: got %h expected %h", PC, 32'h0);
    end
    for (int r = 1; r < 32; r++) begin
      peek(5'(r), v);
      n_checks++;
      if (v !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_reg x%0d: got %h expected %h", r, v, 32'h0);
      end
    end
    Reset = 1'b0;
    tick();
    n_checks++;
    if (PC !== 32'h4) begin
      n_fail++;
      $display("FAIL pc_after_release: got %h expected %h", PC, 32'h4);
    end
    tick();
    n_checks++;
    if (PC !== 32'h8) begin
      n_fail++;
      $display("FAIL pc_second_edge: got %h expected %h", PC, 32'h8);
    end
    exp_pc = 32'h8;
  endtask

  task automatic test_store;
    logic [31:0] v;
    ReadData = 32'hDEAD_BEEF;
    drive(32'h0471AA23, 1'b0, RES_MEM, 1'b1, IMM_S, 1'b0, ALU_ADD);
    #1;
    n_checks++;
    if (ALUResult !== 32'h54) begin
      n_fail++;
      $display("FAIL sw_addr: got %h expected %h", ALUResult, 32'h54);
    end
    n_checks++;
    if (WriteData !== 32'h0) begin
      n_fail++;
      $display("FAIL sw_wdata: got %h expected %h", WriteData, 32'h0);
    end
    n_checks++;
    if (DataSrc !== 3'b010) begin
      n_fail++;
      $display("FAIL sw_datasrc: got %b expected %b", DataSrc, 3'b010);
    end
    n_checks++;
    if (zero_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_zero: got %b expected %b", zero_flag, 1'b0);
    end
    n_checks++;
    if (Final_Result !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL sw_result_mem: got %h expected %h", Final_Result, 32'hDEAD_BEEF);
    end
    tick();
    exp_pc = exp_pc + 32'd4;
    n_checks++;
    if (PC !== exp_pc) begin
      n_fail++;
      $display("FAIL sw_pc: got %h expected %h", PC, exp_pc);
    end
    peek(5'd20, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL sw_no_write x20: got %h expected %h", v, 32'h0);
    end
  endtask

  task automatic test_addi;
    logic [31:0] v;
    drive(32'h00A00293, 1'b0, RES_ALU, 1'b1, IMM_I, 1'b1, ALU_ADD);
    #1;
    n_checks++;
    if (ALUResult !== 32'd10 || Final_Result !== 32'd10) begin
      n_fail++;
      $display("FAIL addi_comb: got alu %h res %h expected %h", ALUResult, Final_Result, 32'd10);
    end
    tick();
    exp_pc = exp_pc + 32'd4;
    peek(5'd5, v);
    n_checks++;
    if (v !== 32'd10) begin
      n_fail++;
      $display("FAIL addi_x5: got %h expected %h", v, 32'd10);
    end
    // addi x5,x5,1: the read before the edge still sees 10.
    drive(i_type(12'd1, 5'd5, 5'd5), 1'b0, RES_ALU, 1'b1, IMM_I, 1'b1, ALU_ADD);
    #1;
    n_checks++;
    if (ALUResult !== 32'd11) begin
      n_fail++;
      $display("FAIL addi_self_before_edge: got %h expected %h", ALUResult, 32'd11);
    end
    tick();
    exp_pc = exp_pc + 32'd4;
    peek(5'd5, v);
    n_checks++;
    if (v !== 32'd11) begin
      n_fail++;
      $display("FAIL addi_self_after_edge: got %h expected %h", v, 32'd11);
    end
    drive(32'h00A00013, 1'b0, RES_ALU, 1'b1, IMM_I, 1'b1, ALU_ADD);
    tick();
    exp_pc = exp_pc + 32'd4;
    peek(5'd0, v);
    n_checks++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL addi_x0: got %h expected %h", v, 32'h0);
    end
    peek(5'd5, v);
    n_checks++;
    if (v !== 32'd11) begin
      n_fail++;
      $display("FAIL addi_x0_side x5: got %h expected %h", v, 32'd11);
    end
  endtask

  task automatic test_alu;
    alu_vec_t vecs [10];
    // x6 = -3; x5 holds 11 from the previous test.
    drive(i_type(12'hFFD, 5'd0, 5'd6), 1'b0, RES_ALU, 1'b1, IMM_I, 1'b1, ALU_ADD);
    tick();
    exp_pc = exp_pc + 32'd4;
    vecs = '{
      '{ALU_ADD, 5'd5, 5'd6, 32'h0000_0008},
      '{ALU_SUB, 5'd5, 5'd6, 32'h0000_000E},
      '{ALU_AND, 5'd5, 5'd6, 32'h0000_0009},
      '{ALU_OR,  5'd5, 5'd6, 32'hFFFF_FFFF},
      '{ALU_XOR, 5'd5, 5'd6, 32'hFFFF_FFF6},
      '{ALU_SLT, 5'd5, 5'd6, 32'h0000_0000},
      '{ALU_SLT, 5'd6, 5'd5, 32'h0000_0001},
      '{ALU_SLL, 5'd5, 5'd6, 32'h6000_0000},
      '{ALU_SRL, 5'd6, 5'd5, 32'h001F_FFFF},
      '{ALU_SUB, 5'd5, 5'd5, 32'h0000_0000}
    };
    for (int i = 0; i < 10; i++) begin
      drive(r_type(vecs[i].rs1, vecs[i].rs2), 1'b0, RES_ALU, 1'b0, IMM_I, 1'b0, vecs[i].op);
      #1;
      n_checks++;
      if (ALUResult !== vecs[i].exp || zero_flag !== (vecs[i].exp == 32'h0)) begin
        n_fail++;
        $display("FAIL alu_vec%0d op %b: got %h zero %b expected %h", i, vecs[i].op,
                 ALUResult, zero_flag, vecs[i].exp);
      end
    end
    // Immediate formats seen through the ImmExt writeback path.
    drive(i_type(12'hFFD, 5'd0, 5'd0), 1'b0, RES_IMM, 1'b1, IMM_I, 1'b0, ALU_ADD);
    #1;
    n_checks++;
    if (Final_Result !== 32'hFFFF_FFFD) begin
      n_fail++;
      $display("FAIL imm_i_neg: got %h expected %h", Final_Result, 32'hFFFF_FFFD);
    end
    drive({7'h7F, 5'd0, 5'd0, 3'b010, 5'b11100, 7'h23}, 1'b0, RES_IMM, 1'b1, IMM_S, 1'b0,
          ALU_ADD);
    #1;
    n_checks++;
    if (Final_Result !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL imm_s_neg: got %h expected %h", Final_Result, 32'hFFFF_FFFC);
    end
    drive(32'hFE000CE3, 1'b0, RES_IMM, 1'b0, IMM_B, 1'b0, ALU_SUB);
    #1;
    n_checks++;
    if (Final_Result !== 32'hFFFF_FFF8) begin
      n_fail++;
      $display("FAIL imm_b_neg: got %h expected %h", Final_Result, 32'hFFFF_FFF8);
    end
    drive(32'h010000EF, 1'b0, RES_PC4, 1'b0, IMM_J, 1'b0, ALU_ADD);
    #1;
    n_checks++;
    if (Final_Result !== exp_pc + 32'd4) begin
      n_fail++;
      $display("FAIL result_pc4: got %h expected %h", Final_Result, exp_pc + 32'd4);
    end
  endtask

  task automatic test_branch;
    drive(32'h00000463, 1'b1, RES_ALU, 1'b0, IMM_B, 1'b0, ALU_SUB);
    #1;
    n_checks++;
    if (zero_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL beq_zero: got %b expected %b", zero_flag, 1'b1);
    end
    tick();
    exp_pc = exp_pc + 32'd8;
    n_checks++;
    if (PC !== exp_pc) begin
      n_fail++;
      $display("FAIL beq_fwd_pc: got %h expected %h", PC, exp_pc);
    end
    drive(32'hFE000CE3, 1'b1, RES_ALU, 1'b0, IMM_B, 1'b0, ALU_SUB);
    tick();
    exp_pc = exp_pc - 32'd8;
    n_checks++;
    if (PC !== exp_pc) begin
      n_fail++;
      $display("FAIL beq_back_pc: got %h expected %h", PC, exp_pc);
    end
  endtask

  task automatic test_jal;
    logic [31:0] p;
    logic [31:0] v;
    p = exp_pc;
    drive(32'h010000EF, 1'b1, RES_PC4, 1'b0, IMM_J, 1'b1, ALU_ADD);
    tick();
    exp_pc = p + 32'd16;
    n_checks++;
    if (PC !== exp_pc) begin
      n_fail++;
      $display("FAIL jal_pc: got %h expected %h", PC, exp_pc);
    end
    peek(5'd1, v);
    n_checks++;
    if (v !== p + 32'd4) begin
      n_fail++;
      $display("FAIL jal_link x1: got %h expected %h", v, p + 32'd4);
    end
  endtask

  task automatic test_mid_reset;
    logic [31:0] v;
    Reset = 1'b1;
    drive(i_type(12'd10, 5'd0, 5'd9), 1'b0, RES_ALU, 1'b1, IMM_I, 1'b1, ALU_ADD);
    tick();
    Reset = 1'b0;
    n_checks++;
    if (PC !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_pc: got %h expected %h", PC, 32'h0);
    end
    for (int r = 1; r < 10; r++) begin
      peek(5'(r), v);
      n_checks++;
      if (v !== 32'h0) begin
        n_fail++;
        $display("FAIL midreset_reg x%0d: got %h expected %h", r, v, 32'h0);
      end
    end
  endtask

  initial begin
    Reset    = 1'b1;
    ReadData = 32'h0;
    exp_pc   = 32'h0;
    drive(32'h0, 1'b0, RES_ALU, 1'b0, IMM_I, 1'b0, ALU_ADD);
    test_reset();
    test_store();
    test_addi();
    test_alu();
    test_branch();
    test_jal();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
